// File: rtl/timer_prescaler.sv
// Power-of-two clock prescaler: one-cycle count-enable tick plus a registered 50% divided clock.
// The selected divisor only changes at a period boundary, so clk_div_o never has runt phases.
module timer_prescaler #(
    parameter int NUM_SEL = 4,
    parameter int CKS_W   = 2
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             en,
    input  logic             div_clr,
    input  logic [CKS_W-1:0] cks,
    output logic             tick_o,
    output logic             clk_div_o,
    output logic [CKS_W-1:0] cks_act_o,
    output logic             sel_err_o
);

    generate
        if (NUM_SEL < 1 || NUM_SEL > (1 << CKS_W)) begin : g_bad_param
            $error("timer_prescaler: NUM_SEL must be in 1..2**CKS_W");
        end
    endgenerate

    localparam logic [CKS_W:0] SEL_LIM = (CKS_W + 1)'(NUM_SEL);

    logic [NUM_SEL-1:0] cnt;
    logic [CKS_W-1:0]   sel_q;
    logic [NUM_SEL-1:0] half_val;
    logic [NUM_SEL-1:0] wrap_val;
    logic               cks_ok;
    logic               wrap;

    // half_val = DIV/2-1 and wrap_val = DIV-1 for DIV = 2^(sel_q+1)
    always_comb begin
        half_val = (NUM_SEL'(1) << sel_q) - NUM_SEL'(1);
        wrap_val = NUM_SEL'({half_val, 1'b1});
    end

    assign cks_ok    = ({1'b0, cks} < SEL_LIM);
    assign wrap      = (cnt == wrap_val);
    assign cks_act_o = sel_q;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt       <= '0;
            sel_q     <= '0;
            tick_o    <= 1'b0;
            clk_div_o <= 1'b0;
            sel_err_o <= 1'b0;
        end else if (div_clr) begin
            cnt       <= '0;
            tick_o    <= 1'b0;
            clk_div_o <= 1'b0;
            sel_err_o <= !cks_ok;
            if (cks_ok) begin
                sel_q <= cks;
            end
        end else if (!en) begin
            tick_o    <= 1'b0;
            sel_err_o <= 1'b0;
        end else if (wrap) begin
            cnt       <= '0;
            tick_o    <= 1'b1;
            clk_div_o <= 1'b0;
            sel_err_o <= !cks_ok;
            if (cks_ok) begin
                sel_q <= cks;
            end
        end else begin
            cnt       <= cnt + 1'b1;
            tick_o    <= 1'b0;
            sel_err_o <= 1'b0;
            if (cnt == half_val) begin
                clk_div_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timer_prescaler.sv
// Scoreboard bench for timer_prescaler: directed scenarios queue expected tick / clk_div edge
// cycles, and a monitor pops and compares them whenever the DUT shows those events.
module tb_timer_prescaler;

    localparam int NUM_SEL = 6;
    localparam int CKS_W   = 3;

    logic             pclk = 1'b0;
    logic             preset_n;
    logic             en;
    logic             div_clr;
    logic [CKS_W-1:0] cks;
    logic             tick_o;
    logic             clk_div_o;
    logic [CKS_W-1:0] cks_act_o;
    logic             sel_err_o;

    typedef struct {
        int cyc;
        int act;
        int err;
    } tick_t;

    tick_t tick_q[$];
    int    rise_q[$];
    int    fall_q[$];
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;
    logic  prev_div = 1'b0;

    timer_prescaler #(.NUM_SEL(NUM_SEL), .CKS_W(CKS_W)) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .en        (en),
        .div_clr   (div_clr),
        .cks       (cks),
        .tick_o    (tick_o),
        .clk_div_o (clk_div_o),
        .cks_act_o (cks_act_o),
        .sel_err_o (sel_err_o)
    );

    always #10 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_tick(int c, int act, int err);
        tick_t t;
        t.cyc = c;
        t.act = act;
        t.err = err;
        tick_q.push_back(t);
    endfunction

    // Monitor: outputs of edge k are sampled 1 time unit after it, when cyc == k.
    always @(posedge pclk) begin
        tick_t e;
        #1;
        if (preset_n) begin
            if (tick_o) begin
                if (tick_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tick_unexpected: got tick at cyc %0d, none expected", cyc);
                end else begin
                    e = tick_q.pop_front();
                    chk("tick_cyc", cyc, e.cyc);
                    chk("tick_act", int'(cks_act_o), e.act);
                    chk("tick_err", int'(sel_err_o), e.err);
                end
            end else if (sel_err_o) begin
                total++;
                bad++;
                $display("FAIL err_unexpected: got sel_err_o=1 at cyc %0d, expected 0", cyc);
            end
            if (clk_div_o && !prev_div) begin
                if (rise_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rise_unexpected: got rise at cyc %0d, none expected", cyc);
                end else begin
                    chk("rise_cyc", cyc, rise_q.pop_front());
                end
            end
            if (!clk_div_o && prev_div) begin
                if (fall_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fall_unexpected: got fall at cyc %0d, none expected", cyc);
                end else begin
                    chk("fall_cyc", cyc, fall_q.pop_front());
                end
            end
        end
        prev_div = clk_div_o;
    end

    task automatic go_to(input int t);
        while (cyc < t) @(negedge pclk);
    endtask

    // Clear with selection s, then enable; returns the cycle after which counting starts.
    task automatic start(input int s, output int c1);
        div_clr = 1'b1;
        en      = 1'b0;
        cks     = CKS_W'(s);
        @(negedge pclk);
        div_clr = 1'b0;
        en      = 1'b1;
        chk("start_act", int'(cks_act_o), s);
        chk("start_div", int'(clk_div_o), 0);
        c1 = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int c2;
        int d;
        preset_n = 1'b0;
        en       = 1'b0;
        div_clr  = 1'b0;
        cks      = '0;
        repeat (3) @(negedge pclk);
        chk("rst_tick", int'(tick_o), 0);
        chk("rst_div", int'(clk_div_o), 0);
        chk("rst_act", int'(cks_act_o), 0);
        chk("rst_err", int'(sel_err_o), 0);
        preset_n = 1'b1;
        @(negedge pclk);

        // frequency per selection: DIV = 2,4,8,16
        for (int s = 0; s < 4; s++) begin
            d = 2 << s;
            start(s, c1);
            for (int k = 1; k <= 3; k++) begin
                push_tick(c1 + k * d, s, 0);
                rise_q.push_back(c1 + d / 2 + (k - 1) * d);
                fall_q.push_back(c1 + k * d);
            end
            go_to(c1 + 3 * d);
        end

        // asynchronous reset mid-period at cks=3, cnt=9
        start(3, c1);
        rise_q.push_back(c1 + 8);
        go_to(c1 + 9);
        preset_n = 1'b0;
        #1;
        chk("mid_rst_tick", int'(tick_o), 0);
        chk("mid_rst_div", int'(clk_div_o), 0);
        chk("mid_rst_act", int'(cks_act_o), 0);
        chk("mid_rst_err", int'(sel_err_o), 0);
        @(negedge pclk);
        preset_n = 1'b1;
        cks      = 3'd1;
        en       = 1'b1;
        c2       = cyc;
        push_tick(c2 + 2, 1, 0);
        push_tick(c2 + 6, 1, 0);
        rise_q.push_back(c2 + 1);
        rise_q.push_back(c2 + 4);
        fall_q.push_back(c2 + 2);
        fall_q.push_back(c2 + 6);
        @(negedge pclk);
        chk("post_rst_act", int'(cks_act_o), 0);
        go_to(c2 + 6);

        // divisor switch 16 -> 2 requested mid-period
        start(3, c1);
        rise_q.push_back(c1 + 8);
        push_tick(c1 + 16, 0, 0);
        fall_q.push_back(c1 + 16);
        rise_q.push_back(c1 + 17);
        push_tick(c1 + 18, 0, 0);
        fall_q.push_back(c1 + 18);
        rise_q.push_back(c1 + 19);
        push_tick(c1 + 20, 0, 0);
        fall_q.push_back(c1 + 20);
        go_to(c1 + 5);
        cks = 3'd0;
        go_to(c1 + 12);
        chk("switch_hold_act", int'(cks_act_o), 3);
        chk("switch_hold_div", int'(clk_div_o), 1);
        go_to(c1 + 20);

        // hold: en low for 7 cycles at cnt=3, DIV=8
        start(2, c1);
        rise_q.push_back(c1 + 11);
        push_tick(c1 + 15, 2, 0);
        fall_q.push_back(c1 + 15);
        go_to(c1 + 3);
        en = 1'b0;
        go_to(c1 + 6);
        chk("hold_div", int'(clk_div_o), 0);
        chk("hold_tick", int'(tick_o), 0);
        go_to(c1 + 10);
        en = 1'b1;
        go_to(c1 + 15);

        // invalid select 7 at wrap, then 5 (DIV=64)
        start(2, c1);
        rise_q.push_back(c1 + 4);
        push_tick(c1 + 8, 2, 1);
        fall_q.push_back(c1 + 8);
        rise_q.push_back(c1 + 12);
        push_tick(c1 + 16, 5, 0);
        fall_q.push_back(c1 + 16);
        rise_q.push_back(c1 + 48);
        push_tick(c1 + 80, 5, 0);
        fall_q.push_back(c1 + 80);
        go_to(c1 + 4);
        cks = 3'd7;
        go_to(c1 + 9);
        chk("err_one_cycle", int'(sel_err_o), 0);
        cks = 3'd5;
        go_to(c1 + 80);

        // div_clr with en=0 at cnt=13, new selection 1
        start(3, c1);
        rise_q.push_back(c1 + 8);
        go_to(c1 + 13);
        en      = 1'b0;
        div_clr = 1'b1;
        cks     = 3'd1;
        fall_q.push_back(c1 + 14);
        @(negedge pclk);
        chk("clr_div", int'(clk_div_o), 0);
        chk("clr_act", int'(cks_act_o), 1);
        chk("clr_tick", int'(tick_o), 0);
        div_clr = 1'b0;
        en      = 1'b1;
        c2      = cyc;
        rise_q.push_back(c2 + 2);
        push_tick(c2 + 4, 1, 0);
        fall_q.push_back(c2 + 4);
        go_to(c2 + 4);
        en = 1'b0;

        repeat (4) @(negedge pclk);
        chk("left_ticks", tick_q.size(), 0);
        chk("left_rises", rise_q.size(), 0);
        chk("left_falls", fall_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
